// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (diff = a - b), LSB first, one full-subtractor stage.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output `ovf`.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t             r_state;
   logic [WIDTH-1:0]   r_ra;
   logic [WIDTH-1:0]   r_rb;
   logic [WIDTH-2:0]   r_res;
   logic               r_br;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_busy;
   logic               r_done;
   logic [WIDTH-1:0]   r_diff;
   logic               r_bout;
`ifdef SERIAL_SUB_OVF_EN
   logic               r_a_msb;
   logic               r_b_msb;
   logic               r_ovf;
`endif

   logic               w_x;
   logic               w_y;
   logic               w_d;
   logic               w_br_next;
   logic [WIDTH-1:0]   w_res_next;
   logic               w_last;
   logic               w_accept;

   // Single full-subtractor stage on the current LSBs.
   assign w_x        = r_ra[0];
   assign w_y        = r_rb[0];
   assign w_d        = w_x ^ w_y ^ r_br;
   assign w_br_next  = (~w_x & w_y) | (~(w_x ^ w_y) & r_br);
   // The result register holds only the upper WIDTH-1 bits; the bit computed
   // this cycle completes the full word, which is exactly what DONE captures.
   assign w_res_next = {w_d, r_res};
   assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
   assign w_accept   = start && (r_state != S_SHIFT);

   // NOTE: sequential state uses non-blocking assignments only, and every
   // register, shift registers included, is cleared by the async reset so an
   // aborted operation leaves no stale partial result behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_ra    <= '0;
         r_rb    <= '0;
         r_res   <= '0;
         r_br    <= 1'b0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_diff  <= '0;
         r_bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         r_a_msb <= 1'b0;
         r_b_msb <= 1'b0;
         r_ovf   <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_SHIFT: begin
               r_ra  <= {1'b0, r_ra[WIDTH-1:1]};
               r_rb  <= {1'b0, r_rb[WIDTH-1:1]};
               r_res <= w_res_next[WIDTH-1:1];
               r_br  <= w_br_next;
               if (w_last) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_diff  <= w_res_next;
                  r_bout  <= w_br_next;
`ifdef SERIAL_SUB_OVF_EN
                  r_ovf   <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_d);
`endif
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: begin
               // IDLE and DONE both accept a new operation; DONE drops its pulse here.
               r_done <= 1'b0;
               if (w_accept) begin
                  r_state <= S_SHIFT;
                  r_busy  <= 1'b1;
                  r_ra    <= a;
                  r_rb    <= b;
                  r_res   <= '0;
                  r_br    <= 1'b0;
                  r_cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
                  r_a_msb <= a[WIDTH-1];
                  r_b_msb <= b[WIDTH-1];
`endif
               end else begin
                  r_state <= S_IDLE;
               end
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign diff = r_diff;
   assign bout = r_bout;
`ifdef SERIAL_SUB_OVF_EN
   assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8); ovf is checked
// only when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf;
`endif

   int n_vec;
   int n_err;

   serial_subtractor #(.WIDTH(WIDTH)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Drives start for one cycle; returns at the negedge just after the sampling edge.
   task automatic start_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
      @(negedge clk);
      a     = av;
      b     = bv;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Counts negedges from c0 until done is seen; returns 99 if the budget expires.
   task automatic wait_done(input int c0, output int c);
      c = c0;
      while (!done && c < 3 * WIDTH) begin
         @(negedge clk);
         c++;
      end
      if (!done) c = 99;
   endtask

   task automatic run_vec(input string tag, input logic [WIDTH-1:0] av,
                          input logic [WIDTH-1:0] bv, input logic [WIDTH-1:0] ed,
                          input logic eb, input logic eo);
      int c;
      start_op(av, bv);
      check({tag, " busy"}, busy, 1'b1);
      wait_done(1, c);
      check({tag, " latency"}, c, WIDTH + 1);
      check({tag, " diff"}, diff, ed);
      check({tag, " bout"}, bout, eb);
`ifdef SERIAL_SUB_OVF_EN
      check({tag, " ovf"}, ovf, eo);
`else
      if (eo === 1'bx) $display("unexpected x in ovf expectation");
`endif
      @(negedge clk);
      check({tag, " pulse"}, done, 1'b0);
      check({tag, " hold"}, diff, ed);
   endtask

   initial begin
      int c;
      int pulses;
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;

      repeat (2) @(negedge clk);
      check("reset busy", busy, 1'b0);
      check("reset done", done, 1'b0);
      check("reset diff", diff, 8'h00);
      check("reset bout", bout, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
      check("reset ovf", ovf, 1'b0);
`endif
      rst_n = 1'b1;
      @(negedge clk);

      run_vec("05-03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
      run_vec("03-05", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
      run_vec("00-FF", 8'h00, 8'hFF, 8'h01, 1'b1, 1'b0);
      run_vec("00-00", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
      run_vec("80-01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
      run_vec("7F-FF", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

      // Start while busy must be ignored.
      start_op(8'h10, 8'h01);
      @(negedge clk);
      @(negedge clk);
      a     = 8'hAA;
      b     = 8'h55;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy-start busy", busy, 1'b1);
      wait_done(4, c);
      check("busy-start latency", c, WIDTH + 1);
      check("busy-start diff", diff, 8'h0F);
      check("busy-start bout", bout, 1'b0);
      pulses = 0;
      for (int i = 0; i < 2 * WIDTH; i++) begin
         @(negedge clk);
         if (done) pulses++;
      end
      check("busy-start extra done", pulses, 0);
      check("busy-start idle", busy, 1'b0);

      // Back-to-back: start held high during the DONE cycle.
      start_op(8'h30, 8'h01);
      wait_done(1, c);
      check("b2b first latency", c, WIDTH + 1);
      check("b2b first diff", diff, 8'h2F);
      a     = 8'h20;
      b     = 8'h10;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("b2b busy rise", busy, 1'b1);
      check("b2b done drop", done, 1'b0);
      check("b2b first held", diff, 8'h2F);
      wait_done(1, c);
      check("b2b spacing", c, WIDTH + 1);
      check("b2b second diff", diff, 8'h10);
      check("b2b second bout", bout, 1'b0);
      @(negedge clk);

      // Asynchronous reset in the middle of SHIFT.
      start_op(8'h55, 8'h22);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort busy", busy, 1'b0);
      check("abort done", done, 1'b0);
      check("abort diff", diff, 8'h00);
      check("abort bout", bout, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
      check("abort ovf", ovf, 1'b0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < WIDTH + 4; i++) begin
         @(negedge clk);
         if (done || busy) pulses++;
      end
      check("abort no activity", pulses, 0);
      run_vec("post-reset 05-03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
